// File: rtl/lab4_branch_resolve_queue.sv
// Branch resolve queue: holds in-flight predicted branches, resolves them oldest-first,
// drives the bimodal predictor update, signals mispredicts and keeps accuracy counters.
module lab4_branch_resolve_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_NBITS  = 32,
  parameter int CNT_NBITS = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alloc_val,
  output logic                         alloc_rdy,
  input  logic [PC_NBITS-1:0]          alloc_pc,
  input  logic                         alloc_pred,
  input  logic                         resolve_val,
  output logic                         resolve_rdy,
  input  logic                         resolve_taken,
  output logic                         update_en,
  output logic [PC_NBITS-1:0]          update_pc,
  output logic                         update_val,
  output logic                         mispredict,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_NBITS-1:0]         num_resolved,
  output logic [CNT_NBITS-1:0]         num_correct
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PC_NBITS-1:0]  r_entryPc [DEPTH];
  logic [DEPTH-1:0]     r_entryPred;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_updateEn;
  logic [PC_NBITS-1:0]  r_updatePc;
  logic                 r_updateVal;
  logic                 r_mispredict;
  logic [CNT_NBITS-1:0] r_numResolved;
  logic [CNT_NBITS-1:0] r_numCorrect;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_allocFire;
  logic                 w_resolveFire;
  logic                 w_headPred;
  logic                 w_mismatch;
  logic [PTR_W-1:0]     w_headInc;
  logic [PTR_W-1:0]     w_tailInc;
  logic [PTR_W-1:0]     w_headNext;
  logic [PTR_W-1:0]     w_tailNext;
  logic [CNT_W-1:0]     w_countNext;

  assign w_full        = (r_count == FULL_COUNT);
  assign w_empty       = (r_count == '0);
  assign w_allocFire   = alloc_val & ~w_full;
  assign w_resolveFire = resolve_val & ~w_empty;
  assign w_headPred    = r_entryPred[r_head];
  assign w_mismatch    = w_resolveFire & (w_headPred != resolve_taken);
  assign w_headInc     = r_head + PTR_W'(1);
  assign w_tailInc     = r_tail + PTR_W'(1);

  // A mispredict flushes every younger entry, including one allocated this same cycle.
  always_comb begin
    w_headNext  = r_head;
    w_tailNext  = r_tail;
    w_countNext = r_count;
    if (w_mismatch) begin
      w_headNext  = w_headInc;
      w_tailNext  = w_headInc;
      w_countNext = '0;
    end else begin
      if (w_resolveFire) w_headNext = w_headInc;
      if (w_allocFire)   w_tailNext = w_tailInc;
      if (w_allocFire && !w_resolveFire)
        w_countNext = r_count + CNT_W'(1);
      else if (!w_allocFire && w_resolveFire)
        w_countNext = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_headNext;
      r_tail  <= w_tailNext;
      r_count <= w_countNext;
    end
  end

  always_ff @(posedge clk) begin
    if (w_allocFire && !w_mismatch) begin
      r_entryPc[r_tail]   <= alloc_pc;
      r_entryPred[r_tail] <= alloc_pred;
    end
  end

  // Update PC/value are sticky; only the strobes drop back to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_updateEn   <= 1'b0;
      r_updatePc   <= '0;
      r_updateVal  <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_updateEn   <= w_resolveFire;
      r_mispredict <= w_mismatch;
      if (w_resolveFire) begin
        r_updatePc  <= r_entryPc[r_head];
        r_updateVal <= resolve_taken;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_numResolved <= '0;
      r_numCorrect  <= '0;
    end else if (w_resolveFire) begin
      if (!(&r_numResolved))
        r_numResolved <= r_numResolved + CNT_NBITS'(1);
      if (!w_mismatch && !(&r_numCorrect))
        r_numCorrect <= r_numCorrect + CNT_NBITS'(1);
    end
  end

  assign alloc_rdy    = ~w_full;
  assign resolve_rdy  = ~w_empty;
  assign count        = r_count;
  assign update_en    = r_updateEn;
  assign update_pc    = r_updatePc;
  assign update_val   = r_updateVal;
  assign mispredict   = r_mispredict;
  assign num_resolved = r_numResolved;
  assign num_correct  = r_numCorrect;

endmodule

// File: tb/tb_lab4_branch_resolve_queue.sv
// Testbench for lab4_branch_resolve_queue: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_lab4_branch_resolve_queue;

  localparam int DEPTH   = 4;
  localparam int PCW     = 32;
  localparam int CNTW    = 6;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk;
  logic            reset_n;
  logic            allocVal;
  logic            allocRdy;
  logic [PCW-1:0]  allocPc;
  logic            allocPred;
  logic            resolveVal;
  logic            resolveRdy;
  logic            resolveTaken;
  logic            updateEn;
  logic [PCW-1:0]  updatePc;
  logic            updateVal;
  logic            mispredict;
  logic [2:0]      count;
  logic [CNTW-1:0] numResolved;
  logic [CNTW-1:0] numCorrect;

  int assertCount = 0;
  int failCount   = 0;

  lab4_branch_resolve_queue #(.DEPTH(DEPTH), .PC_NBITS(PCW), .CNT_NBITS(CNTW)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_val(allocVal), .alloc_rdy(allocRdy), .alloc_pc(allocPc), .alloc_pred(allocPred),
    .resolve_val(resolveVal), .resolve_rdy(resolveRdy), .resolve_taken(resolveTaken),
    .update_en(updateEn), .update_pc(updatePc), .update_val(updateVal),
    .mispredict(mispredict), .count(count),
    .num_resolved(numResolved), .num_correct(numCorrect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic aVal; logic [31:0] aPc; logic aPred; logic rVal; logic rTaken;
    int expCount; logic expUpdEn; logic [31:0] expUpdPc; logic expUpdVal; logic expMisp;
    logic expARdy; logic expRRdy; int expRes; int expCor;
  } vec_t;

  typedef struct { logic [31:0] pc; logic pred; } ent_t;

  // Reference model: a plain queue of in-flight branches plus expected output registers.
  ent_t        mq[$];
  int          mRes, mCor;
  logic        mUpdEn, mUpdVal, mMisp;
  logic [31:0] mUpdPc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic aVal, input logic [31:0] aPc, input logic aPred,
                               input logic rVal, input logic rTaken);
    allocVal = aVal; allocPc = aPc; allocPred = aPred;
    resolveVal = rVal; resolveTaken = rTaken;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    allocVal = 0; allocPc = '0; allocPred = 0; resolveVal = 0; resolveTaken = 0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic modelReset();
    mq.delete();
    mRes = 0; mCor = 0; mUpdEn = 0; mUpdVal = 0; mMisp = 0; mUpdPc = '0;
  endtask

  // Applies the architectural rules for one clock edge with the given inputs.
  task automatic modelStep(input logic aVal, input logic [31:0] aPc, input logic aPred,
                           input logic rVal, input logic rTaken);
    bit   doAlloc, doResolve, bad;
    ent_t e;
    doAlloc   = aVal && (mq.size() < DEPTH);
    doResolve = rVal && (mq.size() > 0);
    bad = 0;
    mUpdEn = 0; mMisp = 0;
    if (doResolve) begin
      e = mq.pop_front();
      bad = (e.pred != rTaken);
      mUpdEn = 1; mUpdPc = e.pc; mUpdVal = rTaken; mMisp = bad;
      if (mRes < CNT_MAX) mRes++;
      if (!bad && mCor < CNT_MAX) mCor++;
      if (bad) mq.delete();
    end
    if (doAlloc && !bad) begin
      e.pc = aPc; e.pred = aPred;
      mq.push_back(e);
    end
  endtask

  vec_t vecs[20];

  initial begin
    reset_n = 1'b0;
    vecs[0]  = '{1, 32'h100, 1, 0, 0, 1, 0, 32'h000, 0, 0, 1, 1, 0, 0};
    vecs[1]  = '{0, 32'h000, 0, 1, 1, 0, 1, 32'h100, 1, 0, 1, 0, 1, 1};
    vecs[2]  = '{0, 32'h000, 0, 0, 0, 0, 0, 32'h100, 1, 0, 1, 0, 1, 1};
    vecs[3]  = '{1, 32'h004, 0, 0, 0, 1, 0, 32'h100, 1, 0, 1, 1, 1, 1};
    vecs[4]  = '{1, 32'h008, 0, 0, 0, 2, 0, 32'h100, 1, 0, 1, 1, 1, 1};
    vecs[5]  = '{1, 32'h00C, 0, 0, 0, 3, 0, 32'h100, 1, 0, 1, 1, 1, 1};
    vecs[6]  = '{1, 32'h010, 0, 0, 0, 4, 0, 32'h100, 1, 0, 0, 1, 1, 1};
    vecs[7]  = '{1, 32'h014, 1, 0, 0, 4, 0, 32'h100, 1, 0, 0, 1, 1, 1};
    vecs[8]  = '{1, 32'h018, 1, 1, 0, 3, 1, 32'h004, 0, 0, 1, 1, 2, 2};
    vecs[9]  = '{0, 32'h000, 0, 1, 0, 2, 1, 32'h008, 0, 0, 1, 1, 3, 3};
    vecs[10] = '{0, 32'h000, 0, 1, 0, 1, 1, 32'h00C, 0, 0, 1, 1, 4, 4};
    vecs[11] = '{0, 32'h000, 0, 1, 0, 0, 1, 32'h010, 0, 0, 1, 0, 5, 5};
    vecs[12] = '{0, 32'h000, 0, 1, 1, 0, 0, 32'h010, 0, 0, 1, 0, 5, 5};
    vecs[13] = '{1, 32'h020, 0, 0, 0, 1, 0, 32'h010, 0, 0, 1, 1, 5, 5};
    vecs[14] = '{1, 32'h024, 1, 0, 0, 2, 0, 32'h010, 0, 0, 1, 1, 5, 5};
    vecs[15] = '{1, 32'h028, 1, 0, 0, 3, 0, 32'h010, 0, 0, 1, 1, 5, 5};
    vecs[16] = '{1, 32'h02C, 0, 1, 1, 0, 1, 32'h020, 1, 1, 1, 0, 6, 5};
    vecs[17] = '{0, 32'h000, 0, 0, 0, 0, 0, 32'h020, 1, 0, 1, 0, 6, 5};
    vecs[18] = '{1, 32'h030, 1, 1, 1, 1, 0, 32'h020, 1, 0, 1, 1, 6, 5};
    vecs[19] = '{0, 32'h000, 0, 1, 1, 0, 1, 32'h030, 1, 0, 1, 0, 7, 6};

    resetDut();
    checkOutput("reset update_en",    updateEn, 0);
    checkOutput("reset update_pc",    updatePc, 0);
    checkOutput("reset update_val",   updateVal, 0);
    checkOutput("reset mispredict",   mispredict, 0);
    checkOutput("reset count",        count, 0);
    checkOutput("reset resolve_rdy",  resolveRdy, 0);
    checkOutput("reset alloc_rdy",    allocRdy, 1);
    checkOutput("reset num_resolved", numResolved, 0);
    checkOutput("reset num_correct",  numCorrect, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].aVal, vecs[i].aPc, vecs[i].aPred, vecs[i].rVal, vecs[i].rTaken);
      checkOutput($sformatf("vec%0d count", i),        count,       vecs[i].expCount);
      checkOutput($sformatf("vec%0d update_en", i),    updateEn,    vecs[i].expUpdEn);
      checkOutput($sformatf("vec%0d update_pc", i),    updatePc,    vecs[i].expUpdPc);
      checkOutput($sformatf("vec%0d update_val", i),   updateVal,   vecs[i].expUpdVal);
      checkOutput($sformatf("vec%0d mispredict", i),   mispredict,  vecs[i].expMisp);
      checkOutput($sformatf("vec%0d alloc_rdy", i),    allocRdy,    vecs[i].expARdy);
      checkOutput($sformatf("vec%0d resolve_rdy", i),  resolveRdy,  vecs[i].expRRdy);
      checkOutput($sformatf("vec%0d num_resolved", i), numResolved, vecs[i].expRes);
      checkOutput($sformatf("vec%0d num_correct", i),  numCorrect,  vecs[i].expCor);
    end

    // Asynchronous reset with two entries in flight and an update strobe pending.
    applyStimulus(1, 32'h40, 1, 0, 0);
    applyStimulus(1, 32'h44, 1, 0, 0);
    applyStimulus(1, 32'h48, 0, 0, 0);
    applyStimulus(0, 32'h0, 0, 1, 1);
    checkOutput("pre-reset update_en", updateEn, 1);
    checkOutput("pre-reset count",     count, 2);
    allocVal = 0; resolveVal = 0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset update_en",    updateEn, 0);
    checkOutput("async reset count",        count, 0);
    checkOutput("async reset num_resolved", numResolved, 0);
    checkOutput("async reset resolve_rdy",  resolveRdy, 0);
    checkOutput("async reset alloc_rdy",    allocRdy, 1);
    #2 reset_n = 1'b1;

    // Counter saturation: 70 correct resolves, then one mispredict.
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1, 32'h200 + 32'(i * 4), 1, 0, 0);
      applyStimulus(0, 32'h0, 0, 1, 1);
      checkOutput($sformatf("sat%0d num_resolved", i), numResolved, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
      checkOutput($sformatf("sat%0d num_correct", i),  numCorrect,  (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
    end
    applyStimulus(1, 32'h300, 1, 0, 0);
    applyStimulus(0, 32'h0, 0, 1, 0);
    checkOutput("sat mispredict",   mispredict, 1);
    checkOutput("sat num_resolved", numResolved, CNT_MAX);
    checkOutput("sat num_correct",  numCorrect, CNT_MAX);

    // Randomized traffic against the reference model.
    resetDut();
    modelReset();
    for (int c = 0; c < 1500; c++) begin
      logic        aVal, aPred, rVal, rTaken;
      logic [31:0] aPc;
      aVal  = ($urandom_range(0, 3) != 0);
      aPc   = $urandom & 32'hFFFF_FFFC;
      aPred = 1'($urandom_range(0, 1));
      rVal  = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) rTaken = mq[0].pred;
      else rTaken = 1'($urandom_range(0, 1));
      modelStep(aVal, aPc, aPred, rVal, rTaken);
      applyStimulus(aVal, aPc, aPred, rVal, rTaken);
      checkOutput($sformatf("rnd%0d count", c),        count,       mq.size());
      checkOutput($sformatf("rnd%0d alloc_rdy", c),    allocRdy,    mq.size() < DEPTH);
      checkOutput($sformatf("rnd%0d resolve_rdy", c),  resolveRdy,  mq.size() > 0);
      checkOutput($sformatf("rnd%0d update_en", c),    updateEn,    mUpdEn);
      checkOutput($sformatf("rnd%0d update_pc", c),    updatePc,    mUpdPc);
      checkOutput($sformatf("rnd%0d update_val", c),   updateVal,   mUpdVal);
      checkOutput($sformatf("rnd%0d mispredict", c),   mispredict,  mMisp);
      checkOutput($sformatf("rnd%0d num_resolved", c), numResolved, mRes);
      checkOutput($sformatf("rnd%0d num_correct", c),  numCorrect,  mCor);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
